x_vector_mem: RTL and testbench

Parametrised, double-buffered storage for the solver's unknown vector x. It supports element-wise write-back from the update datapath and multi-lane vector reads for the matrix-vector unit. Two modes are provided: Jacobi (reads see the previous iteration until an explicit swap) and Gauss-Seidel (in-place, with same-cycle write-to-read forwarding). It replaces the single-shot whole-vector memory with a handshaked, bandwidth-scaled block sitting between the row-update engine and the multiply-accumulate array.

---
 rtl/x_mem_pkg.sv | 20 ++
 rtl/x_mem_bank.sv | 57 +++++
 rtl/x_vector_mem.sv | 170 +++++++++++++++++
 tb/tb_x_vector_mem.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_mem_pkg.sv
// Shared types and helpers for the double-buffered solver x-vector memory.
// Imported by the bank sub-module and the top level.
package x_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        MODE_JACOBI = 1'b0,
        MODE_GS     = 1'b1
    } mode_t;

    // Bit offset of lane k inside a LANES*ELEM_W read beat.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned elem_w);
        return lane * elem_w;
    endfunction

endpackage

// File: rtl/x_mem_bank.sv
// One x-vector bank: LANES independent element-wide RAM columns, so a single
// element write and an aligned LANES-wide read can share one cycle.
module x_mem_bank
    import x_mem_pkg::*;
#(
    parameter int    ELEM_W    = 32,
    parameter int    DEPTH     = 64,
    parameter int    LANES     = 4,
    parameter string INIT_FILE = "",
    parameter int    ADDR_W    = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [ELEM_W-1:0]                   wr_data,
    input  logic                                zero_en,
    input  logic [ADDR_W-$clog2(LANES)-1:0]     zero_row,
    input  logic                                rd_en,
    input  logic [ADDR_W-$clog2(LANES)-1:0]     rd_row,
    output logic [LANES*ELEM_W-1:0]             rd_data
);

    localparam int LANE_W = $clog2(LANES);
    localparam int ROW_W  = ADDR_W - LANE_W;
    localparam int ROWS   = DEPTH / LANES;

    logic [ROW_W-1:0]  wr_row;
    logic [LANE_W-1:0] wr_lane;

    assign wr_row  = wr_addr[ADDR_W-1:LANE_W];
    assign wr_lane = wr_addr[LANE_W-1:0];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ELEM_W-1:0] mem_reg [ROWS];
            logic [ELEM_W-1:0] rd_reg;
            logic              lane_we;

            assign lane_we = wr_en && (wr_lane == LANE_W'(gi));

            // Zero-fill and element writes never overlap, so one write port suffices.
            always_ff @(posedge clk) begin
                if (zero_en) begin
                    mem_reg[zero_row] <= '0;
                end else if (lane_we) begin
                    mem_reg[wr_row] <= wr_data;
                end
                if (rd_en) begin
                    rd_reg <= mem_reg[rd_row];
                end
            end

            assign rd_data[lane_lsb(gi, ELEM_W) +: ELEM_W] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/x_vector_mem.sv
// Double-buffered x-vector store: Jacobi (read old bank until swap) or
// Gauss-Seidel (in place with same-cycle write forwarding), plus bank zero-fill.
module x_vector_mem
    import x_mem_pkg::*;
#(
    parameter int    ELEM_W    = 32,
    parameter int    DEPTH     = 64,
    parameter int    LANES     = 4,
    parameter string INIT_FILE = "",
    parameter int    ADDR_W    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [ELEM_W-1:0]        wr_data,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    input  logic [ADDR_W-1:0]        rd_base,
    output logic                     rd_valid,
    output logic [LANES*ELEM_W-1:0]  rd_data,
    input  logic                     swap,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     addr_err
);

    localparam int               LANE_W    = $clog2(LANES);
    localparam int               ROW_W     = ADDR_W - LANE_W;
    localparam int               ROWS      = DEPTH / LANES;
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

    state_t            state_reg, state_next;
    logic              wsel_reg, wsel_next;
    logic [ROW_W-1:0]  clr_row_reg, clr_row_next;
    logic              clr_both_reg, clr_both_next;
    logic              done_reg, done_next;
    logic              addr_err_reg;
    logic              rd_valid_reg;
    logic              rd_zero_reg;
    logic              rsel_reg;
    logic [LANES-1:0]  fwd_mask_reg;
    logic [ELEM_W-1:0] fwd_data_reg;

    mode_t             cur_mode;
    logic              idle, wr_fire, rd_fire, wr_in_range, wr_commit, rsel;
    logic              fwd_row_hit, unused_lane_bits;
    logic [ROW_W-1:0]  rd_row;
    logic [LANES-1:0]  fwd_mask;
    logic [1:0][LANES*ELEM_W-1:0] bank_rd_data;
    logic [LANES*ELEM_W-1:0]      sel_data;

    assign cur_mode         = mode_t'(mode);
    assign idle             = (state_reg == ST_IDLE);
    assign wr_fire          = wr_valid && idle;
    assign rd_fire          = rd_req_valid && idle;
    assign wr_in_range      = ({1'b0, wr_addr} < DEPTH_LIM);
    assign wr_commit        = wr_fire && wr_in_range;
    assign rd_row           = rd_base[ADDR_W-1:LANE_W];
    assign unused_lane_bits = ^rd_base[LANE_W-1:0];
    assign rsel             = (cur_mode == MODE_GS) ? wsel_reg : ~wsel_reg;
    assign fwd_row_hit      = (cur_mode == MODE_GS) && wr_commit && (wr_addr[ADDR_W-1:LANE_W] == rd_row);

    always_comb begin
        state_next    = state_reg;
        wsel_next     = wsel_reg;
        clr_row_next  = clr_row_reg;
        clr_both_next = clr_both_reg;
        done_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (clear) begin
                    state_next    = ST_CLEAR;
                    clr_row_next  = '0;
                    clr_both_next = (cur_mode == MODE_GS);
                end else if (swap && (cur_mode == MODE_JACOBI)) begin
                    wsel_next = ~wsel_reg;
                    done_next = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_row_next = clr_row_reg + 1'b1;
                if (clr_row_reg == LAST_ROW) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wsel_reg     <= 1'b0;
            clr_row_reg  <= '0;
            clr_both_reg <= 1'b0;
            done_reg     <= 1'b0;
            addr_err_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_zero_reg  <= 1'b1;
            rsel_reg     <= 1'b0;
            fwd_mask_reg <= '0;
            fwd_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wsel_reg     <= wsel_next;
            clr_row_reg  <= clr_row_next;
            clr_both_reg <= clr_both_next;
            done_reg     <= done_next;
            rd_valid_reg <= rd_fire;
            if (wr_fire && !wr_in_range) begin
                addr_err_reg <= 1'b1;
            end
            // Read-side selectors are captured with the request so rd_data holds between reads.
            if (rd_fire) begin
                rd_zero_reg  <= 1'b0;
                rsel_reg     <= rsel;
                fwd_mask_reg <= fwd_mask;
                fwd_data_reg <= wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            x_mem_bank #(
                .ELEM_W   (ELEM_W),
                .DEPTH    (DEPTH),
                .LANES    (LANES),
                .INIT_FILE(INIT_FILE),
                .ADDR_W   (ADDR_W)
            ) u_bank (
                .clk     (clk),
                .wr_en   (wr_commit && (wsel_reg == 1'(gi))),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .zero_en ((state_reg == ST_CLEAR) && (clr_both_reg || (wsel_reg == 1'(gi)))),
                .zero_row(clr_row_reg),
                .rd_en   (rd_fire),
                .rd_row  (rd_row),
                .rd_data (bank_rd_data[gi])
            );
        end
    endgenerate

    assign sel_data = rsel_reg ? bank_rd_data[1] : bank_rd_data[0];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_out
            assign fwd_mask[gi] = fwd_row_hit && (wr_addr[LANE_W-1:0] == LANE_W'(gi));
            assign rd_data[lane_lsb(gi, ELEM_W) +: ELEM_W] =
                rd_zero_reg      ? '0 :
                fwd_mask_reg[gi] ? fwd_data_reg :
                                   sel_data[lane_lsb(gi, ELEM_W) +: ELEM_W];
        end
    endgenerate

    assign wr_ready     = idle;
    assign rd_req_ready = idle;
    assign rd_valid     = rd_valid_reg;
    assign busy         = (state_reg == ST_CLEAR);
    assign done         = done_reg;
    assign addr_err     = addr_err_reg;

endmodule

// File: tb/tb_x_vector_mem.sv
// Directed bench for x_vector_mem: Jacobi hazard/swap, Gauss-Seidel forwarding,
// clear timing, back-to-back reads, reset mid-clear and out-of-range writes.
module tb_x_vector_mem;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         mode = 1'b0, wr_valid = 1'b0, rd_req_valid = 1'b0, swap = 1'b0, clear = 1'b0;
    logic [5:0]   wr_addr = '0, rd_base = '0;
    logic [31:0]  wr_data = '0;
    logic         wr_ready, rd_req_ready, rd_valid, busy, done, addr_err;
    logic [127:0] rd_data;

    logic         o_mode = 1'b0, o_wr_valid = 1'b0, o_rd_req_valid = 1'b0, o_swap = 1'b0, o_clear = 1'b0;
    logic [6:0]   o_wr_addr = '0, o_rd_base = '0;
    logic [31:0]  o_wr_data = '0;
    logic         o_wr_ready, o_rd_req_ready, o_rd_valid, o_busy, o_done, o_addr_err;
    logic [127:0] o_rd_data;

    int n_vec = 0;
    int n_err = 0;

    x_vector_mem #(.ELEM_W(32), .DEPTH(64), .LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_base(rd_base),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .swap(swap), .clear(clear), .busy(busy), .done(done), .addr_err(addr_err)
    );

    x_vector_mem #(.ELEM_W(32), .DEPTH(96), .LANES(4)) u_oob (
        .clk(clk), .rst_n(rst_n), .mode(o_mode),
        .wr_valid(o_wr_valid), .wr_ready(o_wr_ready), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
        .rd_req_valid(o_rd_req_valid), .rd_req_ready(o_rd_req_ready), .rd_base(o_rd_base),
        .rd_valid(o_rd_valid), .rd_data(o_rd_data),
        .swap(o_swap), .clear(o_clear), .busy(o_busy), .done(o_done), .addr_err(o_addr_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic do_write(input int addr, input logic [31:0] data);
        wr_valid = 1'b1;
        wr_addr  = 6'(addr);
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        $display("wr  addr=%0d data=%h", addr, data);
    endtask

    task automatic do_read(input string tag, input int base, input logic [127:0] exp);
        rd_req_valid = 1'b1;
        rd_base      = 6'(base);
        tick();
        rd_req_valid = 1'b0;
        $display("rd  base=%0d data=%h", base, rd_data);
        check_val({tag, "_valid"}, rd_valid, 1'b1);
        check_val({tag, "_data"}, rd_data, exp);
    endtask

    task automatic o_write(input int addr, input logic [31:0] data);
        o_wr_valid = 1'b1;
        o_wr_addr  = 7'(addr);
        o_wr_data  = data;
        check_val("oob_wr_ready", o_wr_ready, 1'b1);
        tick();
        o_wr_valid = 1'b0;
        $display("oob wr addr=%0d data=%h", addr, data);
    endtask

    initial begin
        int busy_cnt, ready_bad, done_cnt;
        logic [127:0] exp;

        // Reset
        tick();
        tick();
        check_val("rst_rd_valid", rd_valid, 1'b0);
        check_val("rst_rd_data", rd_data, '0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_addr_err", addr_err, 1'b0);
        check_val("rst_wr_ready", wr_ready, 1'b1);
        rst_n = 1'b1;

        // Jacobi: preload x[i] = i into both banks
        mode = 1'b0;
        for (int i = 0; i < 64; i++) do_write(i, 32'(i));
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check_val("swap1_done", done, 1'b1);
        tick();
        check_val("swap1_done_low", done, 1'b0);
        for (int i = 0; i < 64; i++) do_write(i, 32'(i));
        swap = 1'b1;
        tick();
        swap = 1'b0;
        $display("swap done=%0b", done);

        // Jacobi hazard: write goes to the hidden bank
        do_write(4, 32'hAAAA_AAAA);
        do_read("jac_old", 4, beat(4, 5, 6, 7));
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check_val("jac_swap_done", done, 1'b1);
        do_read("jac_new", 4, beat(32'hAAAA_AAAA, 5, 6, 7));

        // Gauss-Seidel: same-cycle write forwarding
        mode         = 1'b1;
        wr_valid     = 1'b1;
        wr_addr      = 6'd9;
        wr_data      = 32'h1234;
        rd_req_valid = 1'b1;
        rd_base      = 6'd8;
        tick();
        wr_valid     = 1'b0;
        rd_req_valid = 1'b0;
        $display("wr+rd addr=9 base=8 data=%h", rd_data);
        check_val("gs_fwd_valid", rd_valid, 1'b1);
        check_val("gs_fwd_data", rd_data, beat(8, 32'h1234, 10, 11));
        tick();
        check_val("gs_hold_valid", rd_valid, 1'b0);
        check_val("gs_hold_data", rd_data, beat(8, 32'h1234, 10, 11));
        do_read("gs_unaligned", 10, beat(8, 32'h1234, 10, 11));
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check_val("gs_swap_no_done", done, 1'b0);
        do_read("gs_after_swap", 4, beat(4, 5, 6, 7));

        // Clear (both banks in Gauss-Seidel mode)
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy_cnt  = 0;
        ready_bad = 0;
        done_cnt  = 0;
        for (int c = 0; c < 24; c++) begin
            if (busy) begin
                busy_cnt++;
                if (wr_ready || rd_req_ready || done) ready_bad++;
            end
            if (done) done_cnt++;
            tick();
        end
        $display("clear busy_cycles=%0d done_pulses=%0d", busy_cnt, done_cnt);
        check_val("clr_busy_cycles", 128'(busy_cnt), 128'd16);
        check_val("clr_ready_low", 128'(ready_bad), 128'd0);
        check_val("clr_done_once", 128'(done_cnt), 128'd1);

        // Back-to-back readback of both banks
        for (int m = 1; m >= 0; m--) begin
            mode = 1'(m);
            rd_req_valid = 1'b1;
            for (int r = 0; r < 16; r++) begin
                rd_base = 6'(r * 4);
                tick();
                $display("rd  mode=%0d base=%0d data=%h", m, r * 4, rd_data);
                check_val($sformatf("b2b_valid_m%0d_r%0d", m, r), rd_valid, 1'b1);
                check_val($sformatf("b2b_zero_m%0d_r%0d", m, r), rd_data, '0);
            end
            rd_req_valid = 1'b0;
            tick();
            check_val("b2b_valid_drop", rd_valid, 1'b0);
        end

        // Reset in the middle of a clear
        mode = 1'b1;
        do_write(63, 32'h55);
        do_read("pre_abort", 60, beat(0, 0, 0, 32'h55));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        check_val("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("reset mid-clear busy=%0b", busy);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_wr_ready", wr_ready, 1'b1);
        check_val("abort_rd_valid", rd_valid, 1'b0);
        check_val("abort_rd_data", rd_data, '0);
        check_val("abort_done", done, 1'b0);
        mode = 1'b0;
        do_read("abort_wsel0", 60, beat(0, 0, 0, 32'h55));
        check_val("main_addr_err", addr_err, 1'b0);

        // Out-of-range writes on a DEPTH = 96 instance
        o_mode  = 1'b1;
        o_clear = 1'b1;
        tick();
        o_clear = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        check_val("oob_clear_idle", o_busy, 1'b0);
        o_write(70, 32'h70);
        o_write(95, 32'h95);
        check_val("oob_inrange_err", o_addr_err, 1'b0);
        o_write(96, 32'hDEAD);
        check_val("oob_err_set", o_addr_err, 1'b1);
        o_write(127, 32'hBEEF);
        o_rd_req_valid = 1'b1;
        for (int r = 0; r < 24; r++) begin
            o_rd_base = 7'(r * 4);
            tick();
            exp = '0;
            if (r == 17) exp[95:64] = 32'h70;
            if (r == 23) exp[127:96] = 32'h95;
            $display("oob rd base=%0d data=%h", r * 4, o_rd_data);
            check_val($sformatf("oob_readback_r%0d", r), o_rd_data, exp);
        end
        o_rd_req_valid = 1'b0;
        tick();
        check_val("oob_err_sticky", o_addr_err, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
